// File: rtl/rr_lease_arbiter_pkg.sv
// rr_lease_arbiter_pkg: FSM state encodings and default hold limit shared by the lease arbiter
package rr_lease_arbiter_pkg;
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GRANT   = 2'd1,
    ST_RELEASE = 2'd2
  } state_t;
  localparam int HOLD_MAX_DEF = 8;
endpackage

// File: rtl/rr_pick.sv
// rr_pick: rotating-priority pick of the first asserted req after index last, with wrap
// ports: req (N requests), last (previous winner) -> pick (winner index), valid (any req)
module rr_pick #(
  parameter int N   = 4,
  parameter int IDW = 2
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] last,
  output logic [IDW-1:0] pick,
  output logic           valid
);
  logic [IDW-1:0] w_idx;
  always_comb begin
    pick  = '0;
    w_idx = '0;
    valid = |req;
    for (int k = N; k >= 1; k--) begin
      w_idx = IDW'((int'(last) + k) % N);
      if (req[w_idx]) pick = w_idx;
    end
  end
endmodule

// File: rtl/rr_lease_arbiter.sv
// rr_lease_arbiter: round-robin leasing of one shared resource with release, withdrawal and hold-limit revoke
// ports: clk, rst (async high), req/done (per requester) -> gnt (one-hot), owner_id, busy, timeout (revoke pulse)
module rr_lease_arbiter
  import rr_lease_arbiter_pkg::*;
#(
  parameter int N        = 4,
  parameter int IDW      = 2,
  parameter int HOLD_MAX = HOLD_MAX_DEF,
  parameter int CW       = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   req,
  input  logic [N-1:0]   done,
  output logic [N-1:0]   gnt,
  output logic [IDW-1:0] owner_id,
  output logic           busy,
  output logic           timeout
);
  state_t         r_state, w_state_n;
  logic [N-1:0]   r_gnt, w_gnt_n;
  logic [IDW-1:0] r_owner, w_owner_n, r_last, w_last_n, w_pick;
  logic [CW-1:0]  r_hold, w_hold_n;
  logic           r_busy, r_timeout, w_timeout_n, w_valid, w_rel, w_others, w_limit;
  rr_pick #(.N(N), .IDW(IDW)) u_pick (
    .req  (req),
    .last (r_last),
    .pick (w_pick),
    .valid(w_valid)
  );
  assign w_rel    = done[r_owner] | ~req[r_owner];
  assign w_others = |(req & ~r_gnt);
  assign w_limit  = r_hold == CW'(HOLD_MAX - 1);
  always_comb begin
    w_state_n   = r_state;
    w_gnt_n     = r_gnt;
    w_owner_n   = r_owner;
    w_last_n    = r_last;
    w_hold_n    = r_hold;
    w_timeout_n = 1'b0;
    case (r_state)
      ST_IDLE: if (w_valid) begin
        w_state_n        = ST_GRANT;
        w_gnt_n          = '0;
        w_gnt_n[w_pick]  = 1'b1;
        w_owner_n        = w_pick;
        w_hold_n         = '0;
      end
      ST_GRANT: begin
        w_hold_n = w_limit ? r_hold : r_hold + 1'b1;
        // an explicit release or withdrawal takes precedence over the hold-limit revoke
        if (w_rel || (w_limit && w_others)) begin
          w_state_n   = ST_RELEASE;
          w_gnt_n     = '0;
          w_timeout_n = ~w_rel;
        end
      end
      ST_RELEASE: begin
        w_state_n = ST_IDLE;
        w_last_n  = r_owner;
      end
      default: begin
        w_state_n = ST_IDLE;
        w_gnt_n   = '0;
      end
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_gnt     <= '0;
      r_owner   <= IDW'(N - 1);
      r_last    <= IDW'(N - 1);
      r_hold    <= '0;
      r_busy    <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_state   <= w_state_n;
      r_gnt     <= w_gnt_n;
      r_owner   <= w_owner_n;
      r_last    <= w_last_n;
      r_hold    <= w_hold_n;
      r_busy    <= w_state_n == ST_GRANT;
      r_timeout <= w_timeout_n;
    end
  end
  assign gnt      = r_gnt;
  assign owner_id = r_owner;
  assign busy     = r_busy;
  assign timeout  = r_timeout;
endmodule
